sw_ctrl: RTL and testbench
==========================

# sw_ctrl

Control sequencer for the stopwatch datapath. Takes raw start, pause and lap push-buttons, then synchronizes and debounces them. A four-state run FSM drives the time counters through a one-cycle `tick` enable, a one-cycle counter-clear pulse and a display `freeze` for lap hold. It sits between the board buttons and the seconds/minutes/hours counters, and replaces their free-running divided clock with a single-clock enable.

## Interface
- `TICK_DIV`, default 100_000_000: clk cycles per `tick`, ≥2.
- `DEB_CYCLES`, default 1_000_000: consecutive stable samples required to accept a button level change, ≥2.
- `clk` input, 1: system clock. All logic is rising-edge.
- `clr` input, 1: asynchronous, active-high reset of all state.
- `start` input, 1: raw start button, asynchronous to `clk`.
- `pause` input, 1: raw pause button, asynchronous.
- `lap` input, 1: raw lap/reset button, asynchronous.
- `run` output, 1: high in RUN or LAP.
- `tick` output, 1: one-cycle count enable for the time counters.
- `cnt_clr` output, 1: one-cycle synchronous clear for the time counters.
- `freeze` output, 1: high in LAP. The display holds its last value.
- `state` output, 2: IDLE=00, RUN=01, PAUSED=10, LAP=11.

## Operation
- **Input path**, per button:
  - 2-FF synchronizer, then debouncer holding `deb` level and counter `dcnt`.
  - While sync ≠ `deb`, `dcnt` increments. Sync = `deb` resets `dcnt` to 0.
  - When `dcnt` = DEB_CYCLES−1 and sync ≠ `deb`: `deb` ← sync and `dcnt` ← 0.
  - Rising edge of `deb` gives a one-cycle event (`ev_start`, `ev_pause`, `ev_lap`). Falling edges generate nothing.
- **FSM**, evaluated on events in fixed priority pause > start > lap. The highest-priority event meaningful in the current state wins; all other events that cycle are dropped.
  - IDLE: start → RUN, `div` ← 0. Pause and lap are ignored.
  - RUN: pause → PAUSED. Lap → LAP. Start is ignored.
  - LAP: pause → PAUSED. Lap → RUN. Start is ignored.
  - PAUSED: start → RUN, with `div` retained (resume, no fractional loss). Lap → IDLE with `cnt_clr` pulse and `div` ← 0. Pause is ignored.
- **Prescaler** `div`:
  - Width is ceil(log2(TICK_DIV)).
  - Increments each edge where the pre-edge state is RUN or LAP. Wraps TICK_DIV−1 → 0.
  - Holds in PAUSED and IDLE.
- `tick` = (state ∈ {RUN, LAP}) ∧ (`div` = TICK_DIV−1), decoded from registers with no raw-input paths.
- `cnt_clr` is registered. It is high for exactly the one cycle after the PAUSED→IDLE edge.
- `run` and `freeze` decode from the state register. `freeze` drops the same edge LAP exits.

## Timing
- **Reset:** `clr` high forces asynchronously `state`=IDLE, `run`=0, `tick`=0, `cnt_clr`=0, `freeze`=0, `div`=0, all sync FFs/`deb`/`dcnt`=0. This holds with no clock.
- **Button-to-state latency:** raw high first sampled at edge k gives the state update at edge k+DEB_CYCLES+3. This assumes the input is stable from k on.
- **Glitches:** pulses or bounces shorter than DEB_CYCLES sync-cycles produce no event.
- **First tick:** with RUN entered at edge E from IDLE, `tick` is high during the cycle after edge E+TICK_DIV−1. It then repeats every TICK_DIV cycles, high for exactly 1 cycle.
- **Pause on a tick cycle:** the tick is delivered. `div` wraps to 0 on the same edge PAUSED is entered.
- **Lap transitions:** RUN↔LAP does not disturb `div` or tick cadence.
- **Button held through reset release:** `deb` starts at 0, so the button yields one event. State updates at edge DEB_CYCLES+3 after the first edge with `clr` low.
- **Reset mid-operation:** `clr` asserted between edges clears outputs immediately. No `cnt_clr` pulse is generated by reset; downstream counters receive `clr` directly.

## Test plan
All scenarios use TICK_DIV=10, DEB_CYCLES=4.
1. **Reset and start:** hold `clr` 10 cycles, then check all outputs 0 and `state`=00. Drive `start` high 10 cycles from edge k → `state`=01 and `run`=1 at edge k+7. `tick` pulses at E+9, E+19 and E+29, each exactly 1 cycle wide.
2. **Bounce rejection:** toggle `start` 1,0,1,0,1,0 on consecutive cycles, then hold 0 → `state` stays 00 and no `tick`.
3. **Pause and resume:** pause while `div`=6, so `div`=7 after the PAUSED edge → `state`=10, no `tick` for 50 cycles. Then start → `tick` in the third cycle after RUN entry, then every 10 cycles.
4. **Lap:** in RUN, press `lap` → `state`=11, `freeze`=1, ticks continue every 10 cycles. Press `lap` again → `state`=01 and `freeze`=0 with unchanged cadence.
5. **Clear and priority:** from PAUSED, press `lap` → one-cycle `cnt_clr`, `state`=00, `div`=0. In RUN, press `start` and `pause` simultaneously → `state`=10.
6. **Async reset:** assert `clr` mid-RUN, 3 ns after an edge → `run`, `tick`, `freeze` and `state` go to 0 before the next edge. Keep `start` held across `clr` release → RUN at edge 7 after release.

Source files
------------

// File: rtl/sw_ctrl.sv
// sw_ctrl: stopwatch button conditioning and run sequencer.
// Turns raw buttons into tick / clear / freeze enables for the time counters.
module sw_deb #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic ev
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DMAX = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic          deb;
  logic          deb_q;
  logic [CW-1:0] dcnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync  <= '0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      dcnt  <= '0;
      ev    <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      deb_q <= deb;
      // event registered one stage after the level so the FSM sees no comb path
      ev    <= deb & ~deb_q;
      if (sync[1] == deb) begin
        dcnt <= '0;
      end else if (dcnt == DMAX) begin
        deb  <= sync[1];
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end
endmodule

module sw_ctrl #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       pause,
  input  logic       lap,
  output logic       run,
  output logic       tick,
  output logic       cnt_clr,
  output logic       freeze,
  output logic [1:0] state
);
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    LAP    = 2'b11
  } state_t;

  state_t        st;
  logic [DW-1:0] div;
  logic          ev_start;
  logic          ev_pause;
  logic          ev_lap;
  logic          active;

  sw_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk(clk), .clr(clr), .btn(start), .ev(ev_start)
  );
  sw_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
    .clk(clk), .clr(clr), .btn(pause), .ev(ev_pause)
  );
  sw_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .clk(clk), .clr(clr), .btn(lap), .ev(ev_lap)
  );

  assign active = (st == RUN) || (st == LAP);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st      <= IDLE;
      div     <= '0;
      cnt_clr <= 1'b0;
    end else begin
      cnt_clr <= 1'b0;
      if (active)
        div <= (div == DIV_MAX) ? '0 : div + 1'b1;
      unique case (st)
        IDLE: begin
          if (ev_start) begin
            st  <= RUN;
            div <= '0;
          end
        end
        RUN: begin
          if (ev_pause)    st <= PAUSED;
          else if (ev_lap) st <= LAP;
        end
        LAP: begin
          if (ev_pause)    st <= PAUSED;
          else if (ev_lap) st <= RUN;
        end
        PAUSED: begin
          // resume keeps div so no fraction of a tick is lost
          if (ev_start) begin
            st <= RUN;
          end else if (ev_lap) begin
            st      <= IDLE;
            div     <= '0;
            cnt_clr <= 1'b1;
          end
        end
      endcase
    end
  end

  assign run    = active;
  assign freeze = (st == LAP);
  assign tick   = active && (div == DIV_MAX);
  assign state  = st;
endmodule

// File: tb/tb_sw_ctrl.sv
// tb_sw_ctrl: directed + random button sequences checked against
// a cycle-level behavioural model of the stopwatch sequencer.
module tb_sw_ctrl;
  localparam int TD = 10;
  localparam int DB = 4;
  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_PAUSED = 2'b10;
  localparam logic [1:0] S_LAP    = 2'b11;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       lap = 1'b0;
  logic       run;
  logic       tick;
  logic       cnt_clr;
  logic       freeze;
  logic [1:0] state;

  int n_chk = 0;
  int n_fail = 0;
  int n = 0;
  int ev_cyc = -1;
  logic [2:0] ev_mask = 3'b000;
  logic [1:0] m_st = S_IDLE;
  int m_div = 0;
  logic m_cc = 1'b0;

  sw_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
    .clk(clk), .clr(clr), .start(start), .pause(pause), .lap(lap),
    .run(run), .tick(tick), .cnt_clr(cnt_clr), .freeze(freeze),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, n, o, e);
    end
  endtask

  task automatic check_all();
    logic act;
    act = (m_st == S_RUN) || (m_st == S_LAP);
    chk("state", 32'(state), 32'(m_st));
    chk("run", 32'(run), 32'(act));
    chk("freeze", 32'(freeze), 32'(m_st == S_LAP));
    chk("tick", 32'(tick), 32'(act && (m_div == TD - 1)));
    chk("cnt_clr", 32'(cnt_clr), 32'(m_cc));
  endtask

  task automatic model_reset();
    m_st = S_IDLE;
    m_div = 0;
    m_cc = 1'b0;
    ev_cyc = -1;
  endtask

  // one clock: advance the model by the stopwatch rules, then compare
  task automatic step();
    logic [2:0] e;
    logic act;
    @(posedge clk);
    n++;
    if (clr) begin
      model_reset();
    end else begin
      e = (n == ev_cyc) ? ev_mask : 3'b000;
      act = (m_st == S_RUN) || (m_st == S_LAP);
      m_cc = 1'b0;
      if (act) m_div = (m_div + 1) % TD;
      if (e[1] && act) begin
        m_st = S_PAUSED;
      end else if (e[0] && !act) begin
        if (m_st == S_IDLE) m_div = 0;
        m_st = S_RUN;
      end else if (e[2] && m_st != S_IDLE) begin
        case (m_st)
          S_RUN: m_st = S_LAP;
          S_LAP: m_st = S_RUN;
          default: begin
            m_st = S_IDLE;
            m_cc = 1'b1;
            m_div = 0;
          end
        endcase
      end
    end
    #1 check_all();
  endtask

  // clean press: first sampled next edge k, event lands at edge k+DB+3
  task automatic press(input logic [2:0] m, input int hold);
    {lap, pause, start} = m;
    ev_cyc = n + 1 + DB + 3;
    ev_mask = m;
    repeat (hold) step();
    {lap, pause, start} = 3'b000;
    repeat (12) step();
  endtask

  task automatic glitch(input logic [2:0] m);
    for (int i = 0; i < 3; i++) begin
      {lap, pause, start} = m;
      repeat ($urandom_range(1, DB - 1)) step();
      {lap, pause, start} = 3'b000;
      repeat ($urandom_range(1, 3)) step();
    end
    repeat (6) step();
  endtask

  initial begin
    #1 check_all();
    repeat (10) step();
    clr = 1'b0;

    for (int i = 0; i < 6; i++) begin
      start = (i % 2 == 0);
      step();
    end
    start = 1'b0;
    repeat (10) step();

    press(3'b001, 10);
    repeat (30) step();

    for (int i = 0; i < 20 && m_div != TD - 1; i++) step();
    press(3'b010, 5);
    repeat (50) step();
    press(3'b001, 5);
    repeat (30) step();

    press(3'b100, 5);
    repeat (20) step();
    press(3'b100, 5);
    repeat (10) step();

    press(3'b010, 5);
    press(3'b100, 5);
    repeat (5) step();
    press(3'b001, 5);
    press(3'b011, 5);
    press(3'b001, 5);
    repeat (7) step();

    #2;
    clr = 1'b1;
    start = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (3) step();
    clr = 1'b0;
    ev_cyc = n + 1 + DB + 3;
    ev_mask = 3'b001;
    repeat (10) step();
    start = 1'b0;
    repeat (12) step();

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) < 3)
        press(3'($urandom_range(1, 7)), $urandom_range(DB, DB + 4));
      else
        glitch(3'($urandom_range(1, 7)));
      repeat ($urandom_range(0, 9)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
